// File: rtl/divider_seq_if.sv
// Operand/result bundle for the iterative unsigned divider.
// The requester drives start/operands; the divider returns registered results and status.
interface divider_seq_if #(
   parameter int DW = 14,
   parameter int VW = 4
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          busy;
   logic          done;
   logic          div_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_zero
   );
endinterface

// File: rtl/divider_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock: done DW clocks after accept.
// No backpressure: start is accepted in IDLE/DONE only; requests while busy are dropped.
module divider_seq #(
   parameter int DW = 14,
   parameter int VW = 4
) (
   input  logic            clk,
   input  logic            reset,
   divider_seq_if.slave    bus
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   logic [DW-1:0] dividend_sr;
   logic [VW-1:0] divisor_reg;
   logic [VW:0]   partial;
   logic [DW-1:0] quot_sr;
   logic [CW-1:0] iter_cnt;

   logic [DW-1:0] quotient_reg;
   logic [VW-1:0] remainder_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          div_zero_reg;

   logic [VW:0]   trial;
   logic          fits;
   logic [VW:0]   partial_next;
   logic [DW-1:0] quot_next;
   logic          last_iter;
   logic [1:0]    unused_bits;

   // The top bit of partial is always zero after a restore, so only the low VW bits shift up.
   always_comb begin
      trial        = {partial[VW-1:0], dividend_sr[DW-1]};
      fits         = (trial >= {1'b0, divisor_reg});
      partial_next = trial;
      if (fits) begin
         partial_next = trial - {1'b0, divisor_reg};
      end
      quot_next = {quot_sr[DW-2:0], fits};
      last_iter = (iter_cnt == CW'(DW - 1));
   end

   assign unused_bits = {partial[VW], quot_sr[DW-1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         dividend_sr   <= '0;
         divisor_reg   <= '0;
         partial       <= '0;
         quot_sr       <= '0;
         iter_cnt      <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         div_zero_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  dividend_sr  <= bus.dividend;
                  divisor_reg  <= bus.divisor;
                  partial      <= '0;
                  quot_sr      <= '0;
                  iter_cnt     <= '0;
                  done_reg     <= 1'b0;
                  div_zero_reg <= 1'b0;
                  if (bus.divisor == '0) begin
                     quotient_reg  <= '1;
                     remainder_reg <= '0;
                     div_zero_reg  <= 1'b1;
                     done_reg      <= 1'b1;
                     state         <= DONE;
                  end else begin
                     busy_reg <= 1'b1;
                     state    <= RUN;
                  end
               end
            end

            RUN: begin
               dividend_sr <= {dividend_sr[DW-2:0], 1'b0};
               partial     <= partial_next;
               quot_sr     <= quot_next;
               iter_cnt    <= iter_cnt + 1'b1;
               if (last_iter) begin
                  quotient_reg  <= quot_next;
                  remainder_reg <= partial_next[VW-1:0];
                  busy_reg      <= 1'b0;
                  done_reg      <= 1'b1;
                  state         <= DONE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.quotient  = quotient_reg;
   assign bus.remainder = remainder_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.div_zero  = div_zero_reg;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: cycle-level behavioural model checked every cycle plus directed literal checks.
module tb_divider_seq;

   localparam int DW = 14;
   localparam int VW = 4;

   logic clk;
   logic reset;
   int   cyc;
   int   acc;
   int   n_cmp;
   int   n_fail;

   divider_seq_if #(.DW(DW), .VW(VW)) bus ();

   divider_seq #(.DW(DW), .VW(VW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
      end
   endtask

   // Behavioural model: quotient and remainder come straight from / and %; timing is a countdown.
   logic          m_busy;
   logic          m_done;
   logic          m_dz;
   logic [DW-1:0] m_q;
   logic [VW-1:0] m_r;
   logic [DW-1:0] m_a;
   logic [VW-1:0] m_b;
   int            m_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
         m_q = '0; m_r = '0; m_a = '0; m_b = '0; m_cnt = 0;
      end else if (m_busy) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_q    = m_a / DW'(m_b);
            m_r    = VW'(m_a % DW'(m_b));
         end
      end else if (bus.start) begin
         m_a    = bus.dividend;
         m_b    = bus.divisor;
         m_done = 1'b0;
         m_dz   = 1'b0;
         if (m_b == '0) begin
            m_done = 1'b1;
            m_dz   = 1'b1;
            m_q    = '1;
            m_r    = '0;
         end else begin
            m_busy = 1'b1;
            m_cnt  = DW;
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         chk("model", 64'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_zero}),
                      64'({m_q, m_r, m_busy, m_done, m_dz}));
      end
   end

   // Called at a negedge; the following posedge is the accepting edge.
   task automatic do_start(input logic [DW-1:0] a, input logic [VW-1:0] b);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      acc = cyc + 1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int lat);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (bus.done !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: got done=%b required 1 within 40 cycles", name, bus.done);
      end
      lat = cyc - acc;
   endtask

   task automatic run_op(input string name, input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input int exp_lat, input logic [DW-1:0] eq, input logic [VW-1:0] er,
                         input logic edz);
      int lat;
      do_start(a, b);
      wait_done(name, lat);
      chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({name, "_q"}, 64'(bus.quotient), 64'(eq));
      chk({name, "_r"}, 64'(bus.remainder), 64'(er));
      chk({name, "_dz"}, 64'(bus.div_zero), 64'(edz));
   endtask

   initial begin
      int lat;
      int low_cnt;
      cyc = 0; acc = 0; n_cmp = 0; n_fail = 0;
      reset = 1'b0;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_state", 64'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_zero}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // 9999/10: busy right after accept, result after 14 clocks, held afterwards
      do_start(14'd9999, 4'd10);
      chk("busy_after_accept", 64'(bus.busy), 64'd1);
      chk("q_held_in_run", 64'(bus.quotient), 64'd0);
      wait_done("d9999", lat);
      chk("d9999_lat", 64'(lat), 64'd14);
      chk("d9999_q", 64'(bus.quotient), 64'd999);
      chk("d9999_r", 64'(bus.remainder), 64'd9);
      chk("d9999_busy", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("d9999_hold", 64'({bus.quotient, bus.remainder, bus.done}), 64'({14'd999, 4'd9, 1'b1}));

      run_op("d16383", 14'd16383, 4'd15, 14, 14'd1092, 4'd3, 1'b0);
      run_op("d7_9", 14'd7, 4'd9, 14, 14'd0, 4'd7, 1'b0);
      run_op("d0_7", 14'd0, 4'd7, 14, 14'd0, 4'd0, 1'b0);
      run_op("d13_1", 14'd13, 4'd1, 14, 14'd13, 4'd0, 1'b0);

      // divide by zero: done at the accepting edge, busy never raised
      run_op("dz", 14'd1234, 4'd0, 0, 14'd16383, 4'd0, 1'b1);
      chk("dz_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);

      // second start while busy is ignored
      do_start(14'd9999, 4'd10);
      repeat (4) @(negedge clk);
      bus.dividend = 14'd55; bus.divisor = 4'd10; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ign", lat);
      chk("ign_lat", 64'(lat), 64'd14);
      chk("ign_q", 64'(bus.quotient), 64'd999);
      chk("ign_r", 64'(bus.remainder), 64'd9);

      // start held high: back-to-back runs with done high for a single cycle
      bus.dividend = 14'd55; bus.divisor = 4'd10; bus.start = 1'b1;
      acc = cyc + 1;
      low_cnt = 0;
      @(negedge clk);
      while (bus.done !== 1'b1 && low_cnt < 40) begin
         low_cnt++;
         @(negedge clk);
      end
      chk("held_low_cycles", 64'(low_cnt), 64'd14);
      chk("held_lat", 64'(cyc - acc), 64'd14);
      chk("held_q", 64'(bus.quotient), 64'd5);
      chk("held_r", 64'(bus.remainder), 64'd5);
      acc = cyc + 1;
      @(negedge clk);
      chk("held_done_one_cycle", 64'(bus.done), 64'd0);
      bus.start = 1'b0;
      wait_done("held2", lat);
      chk("held2_lat", 64'(lat), 64'd14);

      // asynchronous reset mid-run aborts the division
      @(negedge clk);
      do_start(14'd9999, 4'd10);
      repeat (5) @(negedge clk);
      chk("pre_reset_busy", 64'(bus.busy), 64'd1);
      #2 reset = 1'b1;
      #1 chk("async_reset", 64'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_zero}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (16) @(negedge clk);
      chk("aborted_no_done", 64'(bus.done), 64'd0);
      run_op("d100", 14'd100, 4'd10, 14, 14'd10, 4'd0, 1'b0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Parametrised iterative unsigned divider. It replaces the fixed divide-by-10 unit with a general dividend / divisor block driven by a single clock. It uses a restoring shift-subtract algorithm that produces one quotient bit per clock, with a proper start/busy/done handshake and divide-by-zero detection. It feeds the display path: binary to decimal digit extraction via repeated /10, with the divisor tied to 10.

Parameters:
DW, 14, dividend and quotient width in bits (must be >= VW, >= 2)
VW, 4, divisor and remainder width in bits (>= 1)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to begin a division; level-sampled on clk when not busy
dividend  input  DW  unsigned dividend; sampled on the accepting edge only
divisor  input  VW  unsigned divisor; sampled on the accepting edge only
quotient  output  DW  unsigned quotient; valid while done=1
remainder  output  VW  unsigned remainder; valid while done=1
busy  output  1  high while a division is in progress
done  output  1  high from completion until the next accepted start or reset
div_zero  output  1  high with done when the accepted divisor was 0

Behaviour:
- Reset (async, active-high): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_zero=0; internal registers cleared. This applies immediately, including mid-operation; an aborted division leaves no partial result.
- States:
  - IDLE: nothing has run since reset.
  - RUN: division in progress.
  - DONE: results held.
- Accept: in IDLE or DONE, start=1 at an edge (edge N) accepts the operation. On that edge:
  - latch dividend into the shift register and divisor into the divisor register;
  - clear the partial remainder (VW+1 bits) and the iteration counter;
  - done<=0, div_zero<=0.
- Accept with divisor=0: skip RUN and go to DONE at edge N. Outputs: quotient = all ones, remainder=0, div_zero=1, done=1, busy stays 0. Visible one cycle after start.
- Accept with divisor!=0: enter RUN with busy<=1.
- Iteration (RUN, edges N+1 .. N+DW), once per edge, MSB first:
  - P = {partial[VW-1:0], dividend_sr[DW-1]};
  - shift dividend_sr left;
  - if P >= {1'b0, divisor}, then partial<=P-divisor and shift 1 into the quotient register; otherwise partial<=P and shift 0 in.
- Width rule: partial is VW+1 bits, so the comparison never overflows. The final remainder always fits in VW bits.
- Completion: on edge N+DW (the last iteration edge):
  - quotient/remainder outputs load the final values;
  - busy<=0, done<=1, state=DONE.
  - Latency is exactly DW clocks from the accepting edge to done high.
- Outputs quotient/remainder change only on completion, a div-zero accept, or reset. They hold their previous values during RUN.
- start while busy (RUN): ignored. Operand changes during RUN have no effect.
- start held high continuously: a new division is accepted on the first edge in DONE. This gives back-to-back operation with done high for exactly one cycle between runs. The bench must sample results on that cycle.
- Edge cases:
  - dividend < divisor: quotient=0, remainder=dividend.
  - dividend=0: quotient=0, remainder=0, full DW-cycle latency.
  - divisor=1: quotient=dividend, remainder=0.
- No combinational path from inputs to outputs.

Test Plan:
- DW=14, VW=4, reset pulse mid-sim -> all outputs 0 asynchronously, before the next clk edge.
- dividend=9999, divisor=10, 1-cycle start -> busy for 14 cycles; done=1 exactly 14 clks after the accepting edge; quotient=999, remainder=9, div_zero=0; outputs held until the next start.
- dividend=16383, divisor=15 -> quotient=1092, remainder=3. Then dividend=7, divisor=9 -> quotient=0, remainder=7.
- divisor=0, dividend=1234 -> one cycle later done=1, div_zero=1, quotient=16383, remainder=0, busy never asserted.
- Start 9999/10, pulse start again with 55/10 at cycle 5 -> second request ignored; result 999 r 9. Then start held high with 55/10 -> next result 5 r 5 after 14 more cycles, done low for 14 cycles in between.
- Start 9999/10, assert reset at cycle 7 for one cycle, then start 100/10 -> first result never appears; second gives 10 r 0 with done at +14.
